// File: rtl/key_cond_pkg.sv
// key_cond_pkg: shared FSM state type, default timing constants and helpers for the key conditioner
package key_cond_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DELAY,
    ST_REPEAT
  } key_state_e;

  localparam int DEF_N_KEYS        = 4;
  localparam int DEF_ACTIVE_LOW    = 1;
  localparam int DEF_DB_CYCLES     = 50_000;
  localparam int DEF_DELAY_CYCLES  = 12_500_000;
  localparam int DEF_REPEAT_CYCLES = 5_000_000;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/key_channel.sv
// key_channel: one push-button channel -- synchronizer, debounce and auto-repeat FSM
//   clk, rst_n       : clock, asynchronous active-low reset
//   key_i            : raw asynchronous button level
//   rep_en_i         : auto-repeat enable, sampled every cycle
//   pressed_o        : debounced level, 1 = held
//   press_pulse_o    : one cycle on the debounced 0->1 transition
//   release_pulse_o  : one cycle on the debounced 1->0 transition
//   act_pulse_o      : press pulse or repeat tick
//   held_long_o      : 1 from the first repeat tick until release
module key_channel
  import key_cond_pkg::*;
#(
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int DELAY_CYCLES  = DEF_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_i,
  input  logic rep_en_i,
  output logic pressed_o,
  output logic press_pulse_o,
  output logic release_pulse_o,
  output logic act_pulse_o,
  output logic held_long_o
);

  localparam int DBW = $clog2(DB_CYCLES);
  // floor of 2 keeps the counter at least one bit wide when both timings are 1
  localparam int RW  = $clog2(max_int(max_int(DELAY_CYCLES, REPEAT_CYCLES), 2));

  logic [1:0]     sync_q;
  logic [DBW-1:0] db_cnt_q, db_cnt_d;
  logic           pressed_q, pressed_d;
  logic           press_q, release_q;
  key_state_e     state_q;
  logic [RW-1:0]  rep_cnt_q;
  logic           act_q, held_q;
  logic           key_n, differs, toggle, rise, fall;

  assign key_n   = (ACTIVE_LOW != 0) ? ~key_i : key_i;
  assign differs = sync_q[1] != pressed_q;
  assign toggle  = differs && (db_cnt_q == DBW'(DB_CYCLES - 1));
  assign rise    = toggle && !pressed_q;
  assign fall    = toggle && pressed_q;

  always_comb begin
    pressed_d = toggle ? ~pressed_q : pressed_q;
    db_cnt_d  = (!differs || toggle) ? '0 : db_cnt_q + DBW'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q    <= '0;
      db_cnt_q  <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[0], key_n};
      db_cnt_q  <= db_cnt_d;
      pressed_q <= pressed_d;
      press_q   <= rise;
      release_q <= fall;
    end
  end

  // A release overrides every state so no tick can coincide with it.
  // With repeat disabled the counter parks at its terminal value so a tick
  // follows one cycle after the enable returns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      rep_cnt_q <= '0;
      act_q     <= 1'b0;
      held_q    <= 1'b0;
    end else begin
      act_q <= rise;
      if (fall) begin
        state_q   <= ST_IDLE;
        rep_cnt_q <= '0;
        held_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: if (rise) begin
            state_q   <= ST_DELAY;
            rep_cnt_q <= '0;
          end
          ST_DELAY: if (rep_cnt_q != RW'(DELAY_CYCLES - 1)) begin
            rep_cnt_q <= rep_cnt_q + RW'(1);
          end else if (rep_en_i) begin
            state_q   <= ST_REPEAT;
            rep_cnt_q <= '0;
            act_q     <= 1'b1;
            held_q    <= 1'b1;
          end
          ST_REPEAT: if (!rep_en_i) begin
            state_q   <= ST_DELAY;
            rep_cnt_q <= RW'(DELAY_CYCLES - 1);
          end else if (rep_cnt_q == RW'(REPEAT_CYCLES - 1)) begin
            rep_cnt_q <= '0;
            act_q     <= 1'b1;
          end else begin
            rep_cnt_q <= rep_cnt_q + RW'(1);
          end
          default: begin
            state_q   <= ST_IDLE;
            rep_cnt_q <= '0;
          end
        endcase
      end
    end
  end

  assign pressed_o       = pressed_q;
  assign press_pulse_o   = press_q;
  assign release_pulse_o = release_q;
  assign act_pulse_o     = act_q;
  assign held_long_o     = held_q;

endmodule

// File: rtl/key_conditioner.sv
// key_conditioner: N_KEYS independent debounced push-button channels with auto-repeat
//   clk, rst_n     : clock, asynchronous active-low reset
//   key_raw        : raw asynchronous button levels
//   rep_en         : per-channel auto-repeat enable
//   pressed        : debounced levels
//   press_pulse    : debounced press pulses
//   release_pulse  : debounced release pulses
//   act_pulse      : press or repeat action pulses
//   held_long      : set from first repeat tick until release
module key_conditioner
  import key_cond_pkg::*;
#(
  parameter int N_KEYS        = DEF_N_KEYS,
  parameter int ACTIVE_LOW    = DEF_ACTIVE_LOW,
  parameter int DB_CYCLES     = DEF_DB_CYCLES,
  parameter int DELAY_CYCLES  = DEF_DELAY_CYCLES,
  parameter int REPEAT_CYCLES = DEF_REPEAT_CYCLES
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_raw,
  input  logic [N_KEYS-1:0] rep_en,
  output logic [N_KEYS-1:0] pressed,
  output logic [N_KEYS-1:0] press_pulse,
  output logic [N_KEYS-1:0] release_pulse,
  output logic [N_KEYS-1:0] act_pulse,
  output logic [N_KEYS-1:0] held_long
);

  for (genvar i = 0; i < N_KEYS; i++) begin : g_ch
    key_channel #(
      .ACTIVE_LOW   (ACTIVE_LOW),
      .DB_CYCLES    (DB_CYCLES),
      .DELAY_CYCLES (DELAY_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES)
    ) u_ch (
      .clk            (clk),
      .rst_n          (rst_n),
      .key_i          (key_raw[i]),
      .rep_en_i       (rep_en[i]),
      .pressed_o      (pressed[i]),
      .press_pulse_o  (press_pulse[i]),
      .release_pulse_o(release_pulse[i]),
      .act_pulse_o    (act_pulse[i]),
      .held_long_o    (held_long[i])
    );
  end

endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: scenario tasks plus randomized run against a timing-rule reference model
module tb_key_conditioner;
  localparam int DB = 4;
  localparam int DL = 10;
  localparam int RP = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [1:0] key_raw = 2'b11;
  logic [1:0] rep_en = 2'b11;
  logic [1:0] pressed, press_pulse, release_pulse, act_pulse, held_long;

  int compared = 0;
  int fails = 0;

  key_conditioner #(
    .N_KEYS(2), .ACTIVE_LOW(1), .DB_CYCLES(DB), .DELAY_CYCLES(DL), .REPEAT_CYCLES(RP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .key_raw(key_raw), .rep_en(rep_en),
    .pressed(pressed), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .act_pulse(act_pulse), .held_long(held_long)
  );

  always #5 clk = ~clk;

  // Reference model: debounced level follows the synchronized input once the last DB
  // samples agree; ticks are scheduled by absolute due times.
  int   mt = 0;
  logic m_s1[2], m_s2[2], m_p[2], m_held[2];
  int   m_due[2];
  logic hist[2][$];
  logic [1:0] e_p, e_pp, e_rp, e_act, e_hl;

  task automatic model_reset();
    for (int k = 0; k < 2; k++) begin
      m_s1[k] = 0; m_s2[k] = 0; m_p[k] = 0; m_held[k] = 0; m_due[k] = 0;
      hist[k].delete();
      repeat (DB) hist[k].push_back(1'b0);
    end
    e_p = 0; e_pp = 0; e_rp = 0; e_act = 0; e_hl = 0;
  endtask

  task automatic model_edge();
    logic np, rise, fall, tick, a1, a0;
    mt++;
    if (!rst_n) begin
      model_reset();
      return;
    end
    for (int k = 0; k < 2; k++) begin
      hist[k].push_back(m_s2[k]);
      if (hist[k].size() > DB) void'(hist[k].pop_front());
      a1 = 1; a0 = 1;
      for (int j = 0; j < hist[k].size(); j++) begin
        a1 &= hist[k][j];
        a0 &= ~hist[k][j];
      end
      np = a1 ? 1'b1 : a0 ? 1'b0 : m_p[k];
      m_s2[k] = m_s1[k];
      m_s1[k] = ~key_raw[k];
      rise = np & ~m_p[k];
      fall = ~np & m_p[k];
      tick = m_p[k] & np & (mt >= m_due[k]) & rep_en[k];
      if (rise) m_due[k] = mt + DL;
      if (tick) begin
        m_due[k] = mt + RP;
        m_held[k] = 1;
      end else if (m_held[k] && np && !rep_en[k]) begin
        m_due[k] = mt + 1;
      end
      if (fall) m_held[k] = 0;
      e_p[k] = np; e_pp[k] = rise; e_rp[k] = fall; e_act[k] = rise | tick; e_hl[k] = m_held[k];
      m_p[k] = np;
    end
  endtask

  task automatic step(input logic [1:0] raw, input logic [1:0] en, input logic rn);
    @(posedge clk);
    model_edge();
    #1;
    key_raw = raw;
    rep_en  = en;
    rst_n   = rn;
    if (!rn) model_reset();
    @(negedge clk);
  endtask

  task automatic start_test();
    step(2'b11, 2'b11, 1'b0);
    step(2'b11, 2'b11, 1'b1);
    repeat (8) step(2'b11, 2'b11, 1'b1);
  endtask

  task automatic test_reset();
    step(2'b00, 2'b11, 1'b0);
    compared++;
    if ({pressed, press_pulse, release_pulse, act_pulse, held_long} !== 10'b0) begin
      fails++;
      $display("FAIL reset_state got=%b exp=0", {pressed, press_pulse, release_pulse, act_pulse, held_long});
    end
    for (int c = 0; c < 8; c++) begin
      step(2'b00, 2'b11, 1'b1);
      compared++;
      if ({pressed, press_pulse} !== {(c >= 6) ? 2'b11 : 2'b00, (c == 6) ? 2'b11 : 2'b00}) begin
        fails++;
        $display("FAIL held_at_reset c=%0d got=%b%b exp_press_at=6", c, pressed, press_pulse);
      end
    end
    step(2'b00, 2'b11, 1'b0);
    compared++;
    if ({pressed, press_pulse, act_pulse, held_long} !== 8'b0) begin
      fails++;
      $display("FAIL async_clear got=%b exp=0", {pressed, press_pulse, act_pulse, held_long});
    end
  endtask

  task automatic test_glitch();
    start_test();
    for (int c = 0; c < 15; c++) begin
      step((c < 3) ? 2'b10 : 2'b11, 2'b11, 1'b1);
      compared++;
      if ({pressed[0], press_pulse[0], act_pulse[0]} !== 3'b000) begin
        fails++;
        $display("FAIL glitch c=%0d got=%b exp=000", c, {pressed[0], press_pulse[0], act_pulse[0]});
      end
    end
  endtask

  task automatic test_hold_repeat();
    logic [3:0] exp;
    start_test();
    for (int c = 0; c < 25; c++) begin
      step(2'b10, 2'b11, 1'b1);
      exp = {c >= 6, c == 6, c == 6 || c == 16 || c == 19 || c == 22, c >= 16};
      compared++;
      if ({pressed[0], press_pulse[0], act_pulse[0], held_long[0]} !== exp) begin
        fails++;
        $display("FAIL hold_repeat c=%0d got=%b exp=%b", c, {pressed[0], press_pulse[0], act_pulse[0], held_long[0]}, exp);
      end
    end
  endtask

  task automatic test_release();
    logic [3:0] exp;
    start_test();
    for (int c = 0; c < 36; c++) begin
      step((c < 20) ? 2'b10 : 2'b11, 2'b11, 1'b1);
      exp = {c >= 6 && c < 26, c == 26, c == 6 || c == 16 || c == 19 || c == 22 || c == 25, c >= 16 && c < 26};
      compared++;
      if ({pressed[0], release_pulse[0], act_pulse[0], held_long[0]} !== exp) begin
        fails++;
        $display("FAIL release c=%0d got=%b exp=%b", c, {pressed[0], release_pulse[0], act_pulse[0], held_long[0]}, exp);
      end
    end
  endtask

  task automatic test_no_repeat();
    int acts = 0;
    int helds = 0;
    start_test();
    for (int c = 0; c < 30; c++) begin
      step(2'b10, 2'b10, 1'b1);
      acts += act_pulse[0];
      helds += held_long[0];
    end
    compared++;
    if (acts != 1 || helds != 0) begin
      fails++;
      $display("FAIL no_repeat acts=%0d held_cycles=%0d exp 1/0", acts, helds);
    end
    step(2'b10, 2'b11, 1'b1);
    step(2'b10, 2'b11, 1'b1);
    compared++;
    if ({act_pulse[0], held_long[0]} !== 2'b11) begin
      fails++;
      $display("FAIL resume_tick got=%b exp=11", {act_pulse[0], held_long[0]});
    end
  endtask

  task automatic test_both();
    start_test();
    for (int c = 0; c < 25; c++) begin
      step(2'b00, 2'b11, 1'b1);
      compared++;
      if (act_pulse !== {2{c == 6 || c == 16 || c == 19 || c == 22}} ||
          {pressed, press_pulse, release_pulse, act_pulse, held_long} !== {e_p, e_pp, e_rp, e_act, e_hl}) begin
        fails++;
        $display("FAIL both c=%0d got=%b exp=%b", c, {pressed, press_pulse, release_pulse, act_pulse, held_long},
                 {e_p, e_pp, e_rp, e_act, e_hl});
      end
    end
  endtask

  task automatic test_reset_mid();
    start_test();
    for (int c = 0; c < 30; c++) begin
      step(2'b10, 2'b11, (c == 17 || c == 18) ? 1'b0 : 1'b1);
      compared++;
      if ((c >= 17 && {pressed[0], press_pulse[0], act_pulse[0], held_long[0]} !== {c >= 25, c == 25, c == 25, 1'b0}) ||
          {pressed, press_pulse, release_pulse, act_pulse, held_long} !== {e_p, e_pp, e_rp, e_act, e_hl}) begin
        fails++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, {pressed, press_pulse, release_pulse, act_pulse, held_long},
                 {e_p, e_pp, e_rp, e_act, e_hl});
      end
    end
  endtask

  task automatic test_random();
    logic [1:0] raw = 2'b11;
    logic [1:0] en = 2'b11;
    logic rn;
    start_test();
    for (int c = 0; c < 4000; c++) begin
      for (int k = 0; k < 2; k++) begin
        if ($urandom_range(0, 14) == 0) raw[k] = ~raw[k];
        if ($urandom_range(0, 24) == 0) en[k] = ~en[k];
      end
      rn = ($urandom_range(0, 499) != 0);
      step(raw, en, rn);
      compared++;
      if ({pressed, press_pulse, release_pulse, act_pulse, held_long} !== {e_p, e_pp, e_rp, e_act, e_hl}) begin
        fails++;
        if (fails < 30)
          $display("FAIL random c=%0d got=%b exp=%b", c, {pressed, press_pulse, release_pulse, act_pulse, held_long},
                   {e_p, e_pp, e_rp, e_act, e_hl});
      end
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_glitch();
    test_hold_repeat();
    test_release();
    test_no_repeat();
    test_both();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, fails);
    $finish;
  end

endmodule
